wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 22 ++
 rtl/wb_regfile_dump_fsm.sv | 86 ++++++++
 rtl/wb_regfile.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared processor definitions for the write-back register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: dump sequencer state encoding, default register-index width,
// register count, and a helper that derives the count from an index width.
package wb_regfile_pkg;

  // Dump sequencer states: idle, presenting words, one-cycle completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

  localparam int REGFILE_RBITS = 5;
  localparam int REGFILE_NREGS = 1 << REGFILE_RBITS;

  function automatic int nregs(input int rbits);
    return 1 << rbits;
  endfunction

endpackage

// File: rtl/wb_regfile_dump_fsm.sv
// Debug dump sequencer: walks register indices 0..2**RBITS-1 once per request.
// Latency: first word presented the cycle after start_i; one word per accepted handshake.
// Backpressure: index holds while ready_i=0; the counter advances only on valid&ready.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            dump request, honoured only when idle
//   ready_i            consumer accepts the presented word
//   valid_o/busy_o     word presented / dump in progress
//   done_o             one-cycle completion pulse
//   addr_o             index of the presented word (0 when nothing presented)
module regfile_dump_fsm
  import wb_regfile_pkg::*;
#(
  parameter int RBITS = REGFILE_RBITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [RBITS-1:0] addr_o
);

  localparam logic [RBITS-1:0] LAST_IDX = '1;

  dump_state_e      state_q;
  logic [RBITS-1:0] cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_DUMP;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (ready_i) begin
            // Last index finishes the dump instead of wrapping back to 0.
            if (cnt_q == LAST_IDX) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  // The counter still holds the last index during DONE; mask it off.
  assign addr_o  = valid_q ? cnt_q : '0;

endmodule

// File: rtl/wb_regfile.sv
// Pipeline register file: write-back port, two zero-latency decode read ports, debug dump.
// Latency: reads combinational; writes visible on the cycle after the write-back edge.
// Backpressure: write/read ports never stall; dump holds its word while dump_ready=0.
// Configuration macro: REGFILE_BYPASS_EN -- when defined, read ports forward the
// same-cycle write-back value; otherwise they return stored contents only.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-low reset
//   WB_result/WB_data/WB_rd/WB_regwrite/WB_memtoreg   write-back from MEM/WB
//   ID_rs/ID_rt -> ID_rs_data/ID_rt_data              decode read ports
//   dump_start/dump_ready -> dump_valid/dump_addr/dump_data/dump_busy/dump_done
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int RBITS = REGFILE_RBITS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NBITS-1:0] WB_result,
  input  logic [NBITS-1:0] WB_data,
  input  logic [RBITS-1:0] WB_rd,
  input  logic             WB_regwrite,
  input  logic             WB_memtoreg,
  input  logic [RBITS-1:0] ID_rs,
  input  logic [RBITS-1:0] ID_rt,
  output logic [NBITS-1:0] ID_rs_data,
  output logic [NBITS-1:0] ID_rt_data,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [RBITS-1:0] dump_addr,
  output logic [NBITS-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  localparam int NREGS = nregs(RBITS);

  logic [NBITS-1:0] regs_q [NREGS];
  logic [NBITS-1:0] wb_wdata_d;
  logic             wb_wen_d;

  assign wb_wdata_d = WB_memtoreg ? WB_data : WB_result;
  // Register 0 is hard-wired to zero, so writes to it are dropped here.
  assign wb_wen_d   = WB_regwrite && (WB_rd != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_wen_d) begin
      regs_q[WB_rd] <= wb_wdata_d;
    end
  end

  logic [NBITS-1:0] rs_stored;
  logic [NBITS-1:0] rt_stored;

  assign rs_stored = (ID_rs == '0) ? '0 : regs_q[ID_rs];
  assign rt_stored = (ID_rt == '0) ? '0 : regs_q[ID_rt];

`ifdef REGFILE_BYPASS_EN
  // Forward the value being written this cycle so decode sees it without a stall.
  assign ID_rs_data = (wb_wen_d && (WB_rd == ID_rs)) ? wb_wdata_d : rs_stored;
  assign ID_rt_data = (wb_wen_d && (WB_rd == ID_rt)) ? wb_wdata_d : rt_stored;
`else
  assign ID_rs_data = rs_stored;
  assign ID_rt_data = rt_stored;
`endif

  regfile_dump_fsm #(
    .RBITS (RBITS)
  ) u_dump (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .start_i (dump_start),
    .ready_i (dump_ready),
    .valid_o (dump_valid),
    .busy_o  (dump_busy),
    .done_o  (dump_done),
    .addr_o  (dump_addr)
  );

  // Dump always shows stored content; it never takes the write-back bypass.
  assign dump_data = dump_valid ? regs_q[dump_addr] : '0;

endmodule
